// File: rtl/t_stream_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : t_stream_monitor_if
// Description : Sample/control inputs and monitor results for the T-stream
//               monitor, grouped as one bus with driver/monitor views.
// Revision    : 1.0 - initial release
// ============================================================================
interface t_stream_monitor_if #(
    parameter int WIDTH = 8
) ();
    logic             sample_en;
    logic             t_in;
    logic             clear;
    logic [WIDTH-1:0] shift_q;
    logic             match;
    logic [7:0]       match_count;
    logic [7:0]       ones_count;
    logic [WIDTH-1:0] frame_q;
    logic             frame_valid;

    // Upstream side: drives strobes and data, observes results
    modport master (
        output sample_en, t_in, clear,
        input  shift_q, match, match_count, ones_count, frame_q, frame_valid
    );

    // Monitor side
    modport slave (
        input  sample_en, t_in, clear,
        output shift_q, match, match_count, ones_count, frame_q, frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/t_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module      : t_stream_monitor
// Description : Samples serial T on a strobe; keeps a history register, an
//               overlapping Moore detector for 1011, saturating ones/match
//               counters and a latched WIDTH-bit frame output.
// Revision    : 1.0 - initial release
// ============================================================================
module t_stream_monitor #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    t_stream_monitor_if.slave mon
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(WIDTH - 1);
    localparam logic [7:0] SAT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] frame_q;
    logic [CNT_W-1:0] frame_cnt;
    logic [7:0]       match_count;
    logic [7:0]       ones_count;
    logic             match;
    logic             frame_valid;

    // A sample is taken only when not overridden by clear (reset handled in the flops)
    logic             sample;
    logic [WIDTH-1:0] shift_next;

    assign sample     = mon.sample_en & ~mon.clear;
    assign shift_next = {shift_q[WIDTH-2:0], mon.t_in};

    // Detector state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Detector next-state: overlapping 1011, advances only on sample edges
    always_comb begin
        next_state = state;
        if (mon.clear) begin
            next_state = IDLE;
        end else if (mon.sample_en) begin
            case (state)
                IDLE:    next_state = mon.t_in ? S1    : IDLE;
                S1:      next_state = mon.t_in ? S1    : S10;
                S10:     next_state = mon.t_in ? S101  : IDLE;
                S101:    next_state = mon.t_in ? S1011 : S10;
                S1011:   next_state = mon.t_in ? S1    : S10;
                default: next_state = IDLE;
            endcase
        end
    end

    // History, counters, frame capture and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            frame_q     <= '0;
            frame_cnt   <= '0;
            match_count <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
            frame_valid <= 1'b0;
        end else if (mon.clear) begin
            // frame_q deliberately survives a soft clear
            shift_q     <= '0;
            frame_cnt   <= '0;
            match_count <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
            frame_valid <= 1'b0;
        end else if (sample) begin
            shift_q <= shift_next;
            match   <= (next_state == S1011);
            if ((next_state == S1011) && (match_count != SAT_MAX)) begin
                match_count <= match_count + 8'd1;
            end
            if (mon.t_in && (ones_count != SAT_MAX)) begin
                ones_count <= ones_count + 8'd1;
            end
            if (frame_cnt == FRAME_LAST) begin
                frame_q     <= shift_next;
                frame_valid <= 1'b1;
                frame_cnt   <= '0;
            end else begin
                frame_valid <= 1'b0;
                frame_cnt   <= frame_cnt + CNT_W'(1);
            end
        end else begin
            match       <= 1'b0;
            frame_valid <= 1'b0;
        end
    end

    assign mon.shift_q     = shift_q;
    assign mon.frame_q     = frame_q;
    assign mon.match_count = match_count;
    assign mon.ones_count  = ones_count;
    assign mon.match       = match;
    assign mon.frame_valid = frame_valid;

endmodule
`default_nettype wire

// File: doc/t_stream_monitor.md
# t_stream_monitor

Downstream consumer of the selectable serial output `T` produced by the X/Y/Z flip-flop datapath. On each sample strobe it captures one bit of `T` and does four things with it:
- shifts it into a history register;
- runs an overlapping Moore detector for the pattern `1011`;
- counts ones and pattern matches with saturation;
- emits a latched frame every `WIDTH` samples for the display/LED stage.

## Interface
- `WIDTH`, default 8: bits per frame and shift register width; legal range 4 to 16.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `sample_en`  input  1  one-cycle strobe; `t_in` is sampled only on edges where this is 1.
- `t_in`  input  1  serial bit, driven from upstream `T`.
- `clear`  input  1  synchronous soft clear; see Operation.
- `shift_q`  output  WIDTH  sample history; LSB is the newest bit.
- `match`  output  1  one-cycle pulse when a `1011` pattern completes.
- `match_count`  output  8  number of matches, saturates at 255.
- `ones_count`  output  8  number of sampled 1s, saturates at 255.
- `frame_q`  output  WIDTH  last completed frame; first sample is the MSB.
- `frame_valid`  output  1  one-cycle pulse when `frame_q` is updated.

## Operation
- Sample edge: a rising edge with `sample_en`=1, `reset`=0 and `clear`=0. With `sample_en`=0, all state holds and `match`/`frame_valid` are 0.
- Shift on a sample edge: `shift_q` <= {`shift_q`[WIDTH-2:0], `t_in`}.
- Detector FSM states: IDLE, S1, S10, S101, S1011. Transitions occur only on sample edges (input 1 / input 0):
  - IDLE: 1 goes to S1; 0 goes to IDLE.
  - S1: 1 goes to S1; 0 goes to S10.
  - S10: 1 goes to S101; 0 goes to IDLE.
  - S101: 1 goes to S1011; 0 goes to S10.
  - S1011: 1 goes to S1; 0 goes to S10. This gives overlap, so `1011011` yields two matches.
- `match` is registered. It is 1 for exactly the one cycle following the sample edge that enters S1011, otherwise 0.
- `match_count` increments on that same edge. At 255 it holds.
- `ones_count` increments on each sample edge with `t_in`=1. At 255 it holds.
- Frame counter: internal, counts 0..WIDTH-1 and advances on each sample edge.
  - On the sample edge where the count is WIDTH-1: `frame_q` <= {`shift_q`[WIDTH-2:0], `t_in`}, `frame_valid` is pulsed, and the count wraps to 0.
- Priority: `reset` > `clear` > sample.
  - `reset` zeroes every register, including `frame_q`; the FSM goes to IDLE.
  - `clear` zeroes `shift_q`, both counters, the frame counter and the FSM (to IDLE). `frame_q` is retained. `match` and `frame_valid` are 0.
  - A sample coinciding with `clear` or `reset` is discarded.

## Timing
- Reset values: `shift_q`=0, `match`=0, `match_count`=0, `ones_count`=0, `frame_q`=0, `frame_valid`=0. The FSM is in IDLE and the frame counter is 0.
- Latency: every output reflects a sample one clock after the sample edge. There is no combinational path from inputs to outputs.
- Back-to-back `sample_en` on consecutive cycles is legal and takes one sample per cycle.
- `match` and `frame_valid` can pulse in the same cycle.
- Reset mid-frame: the frame restarts. The next WIDTH samples form the next frame, and no partial frame is emitted.
- Pulses never stretch: a pulse is followed by 0 on the next cycle unless a new sample re-triggers it.

## Test plan
- Reset: drive `reset`=1 for one edge with arbitrary inputs, then `reset`=0 → every output is 0 and there are no pulses for 5 idle cycles.
- Overlapping match: sample 1,0,1,1,0,1,1 on consecutive strobes → `match` pulses after the 4th and 7th samples only; `match_count`=2; `ones_count`=5.
- Strobe gating: toggle `t_in` for 10 cycles with `sample_en`=0 between samples 2 and 3 of `1011` → a single `match` after the 4th strobe; `shift_q` changes only on strobes.
- Frame, WIDTH=8: sample 1,0,1,1,0,0,1,0 → one `frame_valid` pulse the cycle after the 8th sample; `frame_q`=8'hB2; `ones_count`=4; `match_count`=1.
- Saturation: 300 samples of 1 → `ones_count`=255 and holds; `match_count`=0; `frame_valid` pulsed 37 times.
- Clear/reset mid-operation:
  - Assert `clear` with `sample_en`=1 after 5 samples → counters, `shift_q` and the FSM are 0/IDLE; the sample is discarded; `frame_q` is unchanged. The next 8 samples produce one frame.
  - The same sequence with `reset` instead → `frame_q`=0.
